// File: rtl/clock_pkg.sv
// Shared types and limits for the alarm-clock time-keeping stages.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    HOLD  = 2'b11
  } set_mode_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // Packed BCD orders the same as binary, so the range check is a byte compare.
  function automatic logic bcd_in_range(bcd2_t v, bcd2_t max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD modulo (MAX+1) up/down counter with synchronous load.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  clk_i,
  input  logic  load_i,
  input  bcd2_t load_val_i,
  input  logic  inc_i,
  input  logic  dec_i,
  output bcd2_t value_o,
  output logic  carry_o
);

  bcd2_t value_q;
  bcd2_t value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i && !dec_i) begin
      if (value_q == MAX)
        value_d = '0;
      else if (value_q[3:0] == 4'd9)
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      else
        value_d = value_q + 8'd1;
    end else if (dec_i && !inc_i) begin
      if (value_q == '0)
        value_d = MAX;
      else if (value_q[3:0] == 4'd0)
        value_d = {value_q[7:4] - 4'd1, 4'd9};
      else
        value_d = value_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    value_q <= value_d;
  end

  assign value_o = value_q;
  // Combinational so the next stage can chain in the same cycle.
  assign carry_o = !load_i && inc_i && !dec_i && (value_q == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter with set modes and rollover strobes.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] INIT_HH = 8'h00,
  parameter logic [7:0] INIT_MM = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] set_mode,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       min_roll,
  output logic       day_roll
);

  if (!bcd_in_range(INIT_HH, HOUR_MAX)) begin : g_bad_init_hh
    $error("INIT_HH must be packed BCD in 00..23");
  end
  if (!bcd_in_range(INIT_MM, MIN_MAX)) begin : g_bad_init_mm
    $error("INIT_MM must be packed BCD in 00..59");
  end

  set_mode_t mode;
  logic      run, set_h, set_m;
  logic      up, down;
  logic      sec_carry, min_carry, hr_carry;
  logic      sec_load;
  logic      min_inc, min_dec, hr_inc, hr_dec;
  logic      min_roll_q, min_roll_d;
  logic      day_roll_q, day_roll_d;

  assign mode  = set_mode_t'(set_mode);
  assign run   = (mode == RUN);
  assign set_h = (mode == SET_H);
  assign set_m = (mode == SET_M);
  assign up    = inc && !dec;
  assign down  = dec && !inc;

  // Reset rides on each counter's load so it wins over every other request.
  assign sec_load = rst || (set_m && (up || down));
  assign min_inc  = (run && sec_carry) || (set_m && up);
  assign min_dec  = set_m && down;
  assign hr_inc   = (run && min_carry) || (set_h && up);
  assign hr_dec   = set_h && down;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_i      (clk),
    .load_i     (sec_load),
    .load_val_i (8'h00),
    .inc_i      (run && tick),
    .dec_i      (1'b0),
    .value_o    (ss),
    .carry_o    (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk_i      (clk),
    .load_i     (rst),
    .load_val_i (INIT_MM),
    .inc_i      (min_inc),
    .dec_i      (min_dec),
    .value_o    (mm),
    .carry_o    (min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hr (
    .clk_i      (clk),
    .load_i     (rst),
    .load_val_i (INIT_HH),
    .inc_i      (hr_inc),
    .dec_i      (hr_dec),
    .value_o    (hh),
    .carry_o    (hr_carry)
  );

  assign min_roll_d = run && sec_carry;
  assign day_roll_d = run && sec_carry && min_carry && hr_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_roll_q <= 1'b0;
      day_roll_q <= 1'b0;
    end else begin
      min_roll_q <= min_roll_d;
      day_roll_q <= day_roll_d;
    end
  end

  assign min_roll = min_roll_q;
  assign day_roll = day_roll_q;

endmodule
